shift_sub_divider: RTL and testbench

SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

---
 rtl/div_pkg.sv | 6 +
 rtl/sub_9bit.sv | 9 +
 rtl/shift_sub_divider.sv | 104 ++++++++++
 tb/tb_shift_sub_divider.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared widths and FSM state encoding for the shift/subtract divider
package div_pkg;
  localparam int DIV_W = 8;
  localparam int CNT_W = 3;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/sub_9bit.sv
// sub_9bit: 9-bit subtractor a_i - b_i with borrow out
module sub_9bit (
  input  logic [8:0] a_i,
  input  logic [8:0] b_i,
  output logic [8:0] diff_o,
  output logic       borrow_o
);
  assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};
endmodule

// File: rtl/shift_sub_divider.sv
// shift_sub_divider: 8-bit unsigned restoring divider, one quotient bit per cycle
module shift_sub_divider
  import div_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic [DIV_W-1:0] Dividend,
  input  logic [DIV_W-1:0] Divisor,
  output logic [DIV_W-1:0] Quotient,
  output logic [DIV_W-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);
  state_e           state_q, state_d;
  logic [DIV_W-1:0] w_q, w_d, r_q, r_d, d_q, d_d, quo_q, quo_d, rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [DIV_W:0]   p, diff;
  logic             borrow;
  logic [DIV_W-1:0] r_nxt, w_nxt;

  assign p = {r_q, w_q[DIV_W-1]};

  sub_9bit u_sub (
    .a_i      (p),
    .b_i      ({1'b0, d_q}),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  // No borrow means the partial remainder covers the divisor: keep the difference
  assign r_nxt = borrow ? p[DIV_W-1:0] : diff[DIV_W-1:0];
  assign w_nxt = {w_q[DIV_W-2:0], ~borrow};

  // Next-state logic: capture on accept, iterate in CALC, publish results entering DONE
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (Run) begin
        w_d     = Dividend;
        d_d     = Divisor;
        r_d     = '0;
        cnt_d   = '0;
        state_d = (Divisor == '0) ? DONE : CALC;
        if (Divisor == '0) begin
          quo_d = '1;
          rem_d = Dividend;
          dz_d  = 1'b1;
        end
      end
      CALC: begin
        w_d   = w_nxt;
        r_d   = r_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = DONE;
          quo_d   = w_nxt;
          rem_d   = r_nxt;
          dz_d    = 1'b0;
        end
      end
      DONE:    state_d = Run ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously so an aborted run leaves no trace
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivZero   = dz_q;
  assign Busy      = (state_q == CALC);
  assign Done      = (state_q == DONE);
endmodule

// File: tb/tb_shift_sub_divider.sv
// tb_shift_sub_divider: scoreboard bench for the shift/subtract divider
module tb_shift_sub_divider;
  logic       Clk = 1'b0, Reset_n = 1'b0, Run = 1'b0;
  logic [7:0] Dividend = '0, Divisor = '0;
  logic [7:0] Quotient, Remainder;
  logic       Busy, Done, DivZero;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
    int         busy;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0, cyc = 0, busy_cnt = 0;
  logic done_prev = 1'b0;

  shift_sub_divider dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Run       (Run),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every rising Done pops one expectation
  initial forever begin
    @(negedge Clk);
    if (!Reset_n) begin
      busy_cnt  = 0;
      done_prev = 1'b0;
    end else begin
      if (Busy) busy_cnt++;
      if (Done && !done_prev) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", Quotient, e.q);
          chk("remainder", Remainder, e.r);
          chk("divzero", DivZero, e.dz);
          chk("latency", cyc - e.acc + 1, e.lat);
          chk("busy_cycles", busy_cnt, e.busy);
        end
        busy_cnt = 0;
      end
      done_prev = Done;
    end
  end

  task automatic do_op(input logic [7:0] a, b, eq, er, input logic edz, input int hold, input bit scr);
    exp_t e;
    int   n;
    @(negedge Clk);
    Dividend = a;
    Divisor  = b;
    Run      = 1'b1;
    e.q = eq; e.r = er; e.dz = edz;
    e.lat = edz ? 1 : 9; e.busy = edz ? 0 : 8; e.acc = cyc + 1;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      if (scr) begin
        Dividend = 8'($urandom);
        Divisor  = 8'($urandom);
      end
    end while (!Done && n < 20);
    if (!Done) chk("done_timeout", 0, 1);
    repeat (hold) begin
      @(negedge Clk);
      chk("hold_done", Done, 1);
      chk("hold_busy", Busy, 0);
    end
    Run = 1'b0;
    if (hold > 0) begin
      @(negedge Clk);
      chk("release_idle", Done, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_quotient", Quotient, 0);
    chk("rst_remainder", Remainder, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_divzero", DivZero, 0);
    Reset_n = 1'b1;
    do_op(8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 0, 1'b0);
    do_op(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 0, 1'b0);
    do_op(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 0, 1'b0);
    do_op(8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 0, 1'b0);
    do_op(8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 0, 1'b0);
    do_op(8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 0, 1'b0);
    do_op(8'd77,  8'd0,   8'hFF,  8'd77,  1'b1, 0, 1'b0);
    do_op(8'd10,  8'd3,   8'd3,   8'd1,   1'b0, 0, 1'b0);
    do_op(8'd123, 8'd11,  8'd11,  8'd2,   1'b0, 0, 1'b1);
    do_op(8'd50,  8'd6,   8'd8,   8'd2,   1'b0, 21, 1'b0);
    // Abort a 200/7 run in the middle of CALC
    @(negedge Clk);
    Dividend = 8'd200;
    Divisor  = 8'd7;
    Run      = 1'b1;
    repeat (5) @(negedge Clk);
    chk("pre_abort_busy", Busy, 1);
    Reset_n = 1'b0;
    #1;
    chk("abort_quotient", Quotient, 0);
    chk("abort_remainder", Remainder, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_divzero", DivZero, 0);
    Run = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    do_op(8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 0, 1'b0);
    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
